async_mutex_client: RTL and testbench

- Synchronous requester placed directly upstream of the two-input asynchronous mutex in the CMP lock path. One instance per core side.
- Turns single-cycle lock/unlock commands from the core into a glitch-free, registered four-phase request toward the mutex. Synchronises the asynchronous grant back into the core clock domain.
- Reports lock ownership and errors, and counts contention wait cycles.

---
 rtl/async_mutex_pkg.sv | 14 +
 rtl/async_mutex_client_sync_ff.sv | 18 +
 rtl/async_mutex_client.sv | 119 +++++++++++
 tb/tb_async_mutex_client.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/async_mutex_pkg.sv
// Shared types and default sizing for the asynchronous-mutex requester.
package async_mutex_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HELD = 2'd2,
        REL  = 2'd3
    } state_e;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int CNT_W_DEF       = 16;

endpackage

// File: rtl/async_mutex_client_sync_ff.sv
// N-stage single-bit synchroniser for asynchronous grant lines; deliberately unreset.
module sync_ff #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic d_i,
    output logic q_o
);

    logic [N-1:0] sync_q;

    always_ff @(posedge clk) begin
        sync_q <= {sync_q[N-2:0], d_i};
    end

    assign q_o = sync_q[N-1];

endmodule

// File: rtl/async_mutex_client.sv
// Core-side requester for a two-input asynchronous mutex: registered four-phase
// request, synchronised grant, ownership/error reporting and wait-cycle counting.
module async_mutex_client
    import async_mutex_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             lock_req,
    input  logic             unlock_req,
    output logic             ack,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] wait_cnt,
    output logic             mutex_req,
    input  logic             mutex_grant
);

    localparam int SET_W = $clog2(SYNC_STAGES + 1);

    state_e           state_q, state_d;
    logic             grant_s;
    logic             both;
    logic             settled;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic             mreq_q, mreq_d;
    logic             locked_q, locked_d;
    logic             rstrel_q, rstrel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SET_W-1:0] settle_q, settle_d;

    sync_ff #(.N(SYNC_STAGES)) u_grant_sync (
        .clk (clk),
        .d_i (mutex_grant),
        .q_o (grant_s)
    );

    assign both    = lock_req && unlock_req;
    assign settled = (settle_q == SET_W'(SYNC_STAGES));

    // Reset parks in REL so a grant still held by the mutex is waited out.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= REL;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            mreq_q   <= 1'b0;
            locked_q <= 1'b0;
            rstrel_q <= 1'b1;
            cnt_q    <= '0;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            mreq_q   <= mreq_d;
            locked_q <= locked_d;
            rstrel_q <= rstrel_d;
            cnt_q    <= cnt_d;
            settle_q <= settle_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (lock_req && !unlock_req) state_d = REQ;
            REQ:  if (grant_s) state_d = HELD;
            HELD: if (unlock_req && !lock_req) state_d = REL;
            REL:  if (settled && !grant_s) state_d = IDLE;
            default: state_d = REL;
        endcase
    end

    // Request and ownership come from next state so both leave the chip straight from flops.
    always_comb begin
        mreq_d   = (state_d == REQ) || (state_d == HELD);
        locked_d = (state_d == HELD);
        ack_d    = 1'b0;
        err_d    = both;
        rstrel_d = rstrel_q;
        cnt_d    = cnt_q;
        settle_d = settle_q;
        unique case (state_q)
            IDLE: begin
                err_d = both || unlock_req;
                if (state_d == REQ) cnt_d = '0;
            end
            REQ: begin
                err_d = lock_req || unlock_req;
                if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                ack_d = (state_d == HELD);
            end
            HELD: begin
                ack_d = lock_req && !unlock_req;
                if (state_d == REL) settle_d = '0;
            end
            REL: begin
                err_d = lock_req || unlock_req;
                if (!settled) settle_d = settle_q + SET_W'(1);
                if (state_d == IDLE) begin
                    ack_d    = !rstrel_q;
                    rstrel_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign ack       = ack_q;
    assign err       = err_q;
    assign mutex_req = mreq_q;
    assign locked    = locked_q;
    assign wait_cnt  = cnt_q;

endmodule

// File: tb/tb_async_mutex_client.sv
// Bench for async_mutex_client: per-cycle vector table with a scoreboard queue on one
// instance, plus a two-instance arbitration sequence through a behavioural mutex.
module tb_async_mutex_client;

    localparam int SYNC = 2;

    typedef struct {
        bit         rn;
        bit         lk;
        bit         ul;
        bit         hd;
        bit         kp;
        bit [3:0]   exp;
        bit         cc;
        int         cnt;
    } vec_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Single instance with a controllable mutex model
    logic        rn0, lk0, ul0, hold0, keep0;
    logic        ack0, locked0, err0, mreq0, gnt0;
    logic [15:0] cnt0;

    assign gnt0 = (mreq0 & ~hold0) | keep0;

    async_mutex_client #(.SYNC_STAGES(SYNC), .CNT_W(16)) dut0 (
        .clk        (clk),
        .reset_n    (rn0),
        .lock_req   (lk0),
        .unlock_req (ul0),
        .ack        (ack0),
        .locked     (locked0),
        .err        (err0),
        .wait_cnt   (cnt0),
        .mutex_req  (mreq0),
        .mutex_grant(gnt0)
    );

    // Two instances sharing a behavioural mutex
    logic       prn;
    logic [1:0] plk, pul, pack, plocked, perr, preq;
    logic [1:0] pgnt = 2'b00;
    logic [3:0] pcnt0, pcnt1;
    int         owner = -1;
    bit         both_seen = 1'b0;

    always @(preq[0], preq[1]) begin
        if (owner == 0 && preq[0] !== 1'b1) owner = -1;
        if (owner == 1 && preq[1] !== 1'b1) owner = -1;
        if (owner == -1) begin
            if (preq[0] === 1'b1) owner = 0;
            else if (preq[1] === 1'b1) owner = 1;
        end
        pgnt[0] = (owner == 0);
        pgnt[1] = (owner == 1);
    end

    always @(negedge clk) if (plocked[0] === 1'b1 && plocked[1] === 1'b1) both_seen = 1'b1;

    async_mutex_client #(.SYNC_STAGES(SYNC), .CNT_W(4)) dut_a (
        .clk(clk), .reset_n(prn), .lock_req(plk[0]), .unlock_req(pul[0]),
        .ack(pack[0]), .locked(plocked[0]), .err(perr[0]), .wait_cnt(pcnt0),
        .mutex_req(preq[0]), .mutex_grant(pgnt[0])
    );

    async_mutex_client #(.SYNC_STAGES(SYNC), .CNT_W(4)) dut_b (
        .clk(clk), .reset_n(prn), .lock_req(plk[1]), .unlock_req(pul[1]),
        .ack(pack[1]), .locked(plocked[1]), .err(perr[1]), .wait_cnt(pcnt1),
        .mutex_req(preq[1]), .mutex_grant(pgnt[1])
    );

    vec_t vecs[$];
    vec_t exp_q[$];

    function automatic void v(bit rn, bit lk, bit ul, bit hd, bit kp, bit [3:0] e, bit cc, int c);
        vec_t r;
        r.rn = rn; r.lk = lk; r.ul = ul; r.hd = hd; r.kp = kp;
        r.exp = e; r.cc = cc; r.cnt = c;
        vecs.push_back(r);
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_side(int side, int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if (plocked[side] === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic wait_ack(int side, int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if (pack[side] === 1'b1) ok = 1'b1;
        end
    endtask

    initial begin
        vec_t  e;
        string nm;
        bit    ok;
        int    w;
        int    l;

        // Expected bits are {mutex_req, locked, ack, err} after the edge that samples the row.
        v(0,0,0,0,0, 4'b0000, 1, 0);
        v(0,0,0,0,0, 4'b0000, 1, 0);
        for (int i = 0; i < 4; i++) v(1,0,0,0,0, 4'b0000, 0, 0);
        v(1,1,0,0,0, 4'b1000, 1, 0);
        v(1,0,0,0,0, 4'b1000, 0, 0);
        v(1,0,0,0,0, 4'b1000, 0, 0);
        v(1,0,0,0,0, 4'b1110, 1, 3);
        v(1,0,0,0,0, 4'b1100, 0, 0);
        v(1,1,0,0,0, 4'b1110, 0, 0);
        v(1,1,1,0,0, 4'b1101, 0, 0);
        v(1,0,1,0,0, 4'b0000, 0, 0);
        v(1,0,0,0,0, 4'b0000, 0, 0);
        v(1,0,0,0,0, 4'b0000, 0, 0);
        v(1,0,0,0,0, 4'b0010, 0, 0);
        v(1,0,1,0,0, 4'b0001, 0, 0);
        v(1,0,0,0,0, 4'b0000, 0, 0);
        // Contention: grant withheld for 39 cycles after mutex_req rises
        v(1,1,0,1,0, 4'b1000, 1, 0);
        for (int j = 1; j <= 39; j++) begin
            if (j == 5) v(1,1,0,1,0, 4'b1001, 0, 0);
            else        v(1,0,0,1,0, 4'b1000, 0, 0);
        end
        v(1,0,0,0,0, 4'b1000, 0, 0);
        v(1,0,0,0,0, 4'b1000, 0, 0);
        v(1,0,0,0,0, 4'b1110, 1, 40 + SYNC);
        v(1,0,0,0,0, 4'b1100, 0, 0);
        // Reset while held, mutex keeps granting for 10 more cycles
        v(0,0,0,0,1, 4'b0000, 1, 0);
        for (int j = 0; j < 10; j++) begin
            if (j == 4) v(1,1,0,0,1, 4'b0001, 0, 0);
            else        v(1,0,0,0,1, 4'b0000, 0, 0);
        end
        v(1,0,0,0,0, 4'b0000, 0, 0);
        v(1,0,0,0,0, 4'b0000, 0, 0);
        v(1,0,0,0,0, 4'b0000, 0, 0);
        v(1,1,0,0,0, 4'b1000, 1, 0);
        v(1,0,0,0,0, 4'b1000, 0, 0);
        v(1,0,0,0,0, 4'b1000, 0, 0);
        v(1,0,0,0,0, 4'b1110, 1, 3);
        v(1,0,1,0,0, 4'b0000, 0, 0);
        v(1,0,0,0,0, 4'b0000, 0, 0);
        v(1,0,0,0,0, 4'b0000, 0, 0);
        v(1,0,0,0,0, 4'b0010, 0, 0);

        rn0 = 1'b0; lk0 = 1'b0; ul0 = 1'b0; hold0 = 1'b0; keep0 = 1'b0;
        prn = 1'b0; plk = 2'b00; pul = 2'b00;
        tick();

        foreach (vecs[i]) begin
            rn0 = vecs[i].rn; lk0 = vecs[i].lk; ul0 = vecs[i].ul;
            hold0 = vecs[i].hd; keep0 = vecs[i].kp;
            exp_q.push_back(vecs[i]);
            tick();
            e = exp_q.pop_front();
            nm = $sformatf("row%0d_outs", i);
            chk(nm, {28'd0, mreq0, locked0, ack0, err0}, {28'd0, e.exp});
            if (e.cc) begin
                nm = $sformatf("row%0d_wait_cnt", i);
                chk(nm, {16'd0, cnt0}, e.cnt);
            end
        end
        lk0 = 1'b0; ul0 = 1'b0;

        // Two-sided arbitration
        prn = 1'b0;
        tick(); tick();
        prn = 1'b1;
        repeat (6) tick();
        chk("pair_idle", {28'd0, preq, plocked}, 32'd0);
        plk = 2'b11;
        tick();
        plk = 2'b00;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (plocked != 2'b00) ok = 1'b1;
            else tick();
        end
        chk("pair_first_grant_seen", {31'd0, ok}, 32'd1);
        chk("pair_one_locked", {30'd0, plocked}, plocked[0] ? 32'd1 : 32'd2);
        w = plocked[0] ? 0 : 1;
        l = 1 - w;
        repeat (20) tick();
        chk("pair_loser_waiting", {30'd0, preq[l], plocked[l]}, 32'd2);
        pul[w] = 1'b1;
        tick();
        pul[w] = 1'b0;
        wait_side(l, 40, ok);
        chk("pair_loser_granted", {31'd0, ok}, 32'd1);
        chk("pair_loser_ack", {31'd0, pack[l]}, 32'd1);
        chk("pair_wait_sat", {28'd0, (l == 0) ? pcnt0 : pcnt1}, 32'd15);
        chk("pair_winner_released", {31'd0, plocked[w]}, 32'd0);
        pul[l] = 1'b1;
        tick();
        pul[l] = 1'b0;
        wait_ack(l, 20, ok);
        chk("pair_loser_release_ack", {31'd0, ok}, 32'd1);
        chk("pair_never_both_locked", {31'd0, both_seen}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
